// File: rtl/regfile_sequencer.sv
// Multi-cycle command sequencer in front of a single-port register file.
// Each command is a short sequence of reads on the shared address port, then one write.
module regfile_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [2:0]            i_cmd_op,
    input  logic [ADDR_WIDTH-1:0] i_cmd_dst,
    input  logic [ADDR_WIDTH-1:0] i_cmd_src,
    input  logic [DATA_WIDTH-1:0] i_cmd_imm,
    output logic [ADDR_WIDTH-1:0] o_rf_address,
    output logic                  o_rf_write_enable,
    output logic [DATA_WIDTH-1:0] o_rf_write_data,
    input  logic [DATA_WIDTH-1:0] i_rf_read_data,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_flag_zero,
    output logic                  o_flag_carry
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_RD  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_DST,
        S_RD_SRC,
        S_WRITE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_carry;

    logic                  w_accept;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_wval;
    logic                  w_is_alu;
    logic                  w_carry;

    assign w_accept = (r_state == S_IDLE) && i_cmd_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (i_cmd_op)
                        OP_NOP:  w_next = S_IDLE;
                        OP_LDI:  w_next = S_WRITE;
                        OP_MOV:  w_next = S_RD_SRC;
                        default: w_next = S_RD_DST;
                    endcase
                end
            end
            S_RD_DST: w_next = (r_op == OP_RD) ? S_IDLE : S_RD_SRC;
            S_RD_SRC: w_next = S_WRITE;
            S_WRITE:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // One extra bit so bit DATA_WIDTH carries ADD carry-out and SUB borrow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_wval   = '0;
        w_is_alu = 1'b0;
        w_carry  = 1'b0;
        case (r_op)
            OP_LDI: w_wval = {1'b0, r_imm};
            OP_MOV: w_wval = {1'b0, r_b};
            OP_ADD: begin
                w_wval   = w_sum;
                w_is_alu = 1'b1;
                w_carry  = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                w_wval   = w_diff;
                w_is_alu = 1'b1;
                w_carry  = w_diff[DATA_WIDTH];
            end
            OP_AND: begin
                w_wval   = {1'b0, r_a & r_b};
                w_is_alu = 1'b1;
            end
            OP_XOR: begin
                w_wval   = {1'b0, r_a ^ r_b};
                w_is_alu = 1'b1;
            end
            default: w_wval = '0;
        endcase
    end

    always_comb begin
        o_rf_address    = '0;
        o_rf_write_data = '0;
        case (r_state)
            S_RD_DST: o_rf_address = r_dst;
            S_RD_SRC: o_rf_address = r_src;
            S_WRITE: begin
                o_rf_address    = r_dst;
                o_rf_write_data = w_wval[DATA_WIDTH-1:0];
            end
            default: o_rf_address = '0;
        endcase
    end

    // Reset gates the strobe directly so an aborted command can never write.
    assign o_rf_write_enable = (r_state == S_WRITE) && i_reset;
    assign o_cmd_ready       = (r_state == S_IDLE);
    assign o_done            = r_done;
    assign o_result          = r_result;
    assign o_flag_zero       = r_zero;
    assign o_flag_carry      = r_carry;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NOP;
            r_dst    <= '0;
            r_src    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= i_cmd_op;
                        r_dst <= i_cmd_dst;
                        r_src <= i_cmd_src;
                        r_imm <= i_cmd_imm;
                        if (i_cmd_op == OP_NOP) r_done <= 1'b1;
                    end
                end
                S_RD_DST: begin
                    r_a <= i_rf_read_data;
                    if (r_op == OP_RD) begin
                        r_done   <= 1'b1;
                        r_result <= i_rf_read_data;
                    end
                end
                S_RD_SRC: r_b <= i_rf_read_data;
                S_WRITE: begin
                    r_done   <= 1'b1;
                    r_result <= w_wval[DATA_WIDTH-1:0];
                    if (w_is_alu) begin
                        r_zero  <= (w_wval[DATA_WIDTH-1:0] == '0);
                        r_carry <= w_carry;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed table, corner-case sequences, random commands
// checked against an arithmetic model of the register file and flags.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_dst;
    logic [3:0] cmd_src;
    logic [7:0] cmd_imm;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata;
    logic       done;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_carry;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_dst(cmd_dst), .i_cmd_src(cmd_src), .i_cmd_imm(cmd_imm),
        .o_rf_address(rf_addr), .o_rf_write_enable(rf_we), .o_rf_write_data(rf_wdata),
        .i_rf_read_data(rf_rdata), .o_done(done), .o_result(result),
        .o_flag_zero(flag_zero), .o_flag_carry(flag_carry)
    );

    // Register file attached to the DUT
    logic [7:0] rf [16];
    logic       tb_clr;
    assign rf_rdata = rf[rf_addr];
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
        end
    end

    // Reference model state
    logic [7:0] m_rf [16];
    logic [7:0] m_result;
    logic       m_z;
    logic       m_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s,
                               input logic [7:0] im, output int lat, output int nw,
                               output logic [7:0] w);
        int a, b, r;
        a = int'(m_rf[d]);
        b = int'(m_rf[s]);
        w = 8'h00;
        nw = 1;
        case (op)
            3'd0: begin lat = 1; nw = 0; end
            3'd1: begin lat = 2; w = im; end
            3'd2: begin lat = 3; w = m_rf[s]; end
            3'd6: begin lat = 2; nw = 0; m_result = m_rf[d]; end
            default: begin
                lat = 4;
                case (op)
                    3'd3: begin r = a + b; m_c = (r > 255); end
                    3'd4: begin r = a - b; m_c = (a < b); if (r < 0) r += 256; end
                    3'd5: begin r = a & b; m_c = 1'b0; end
                    default: begin r = a ^ b; m_c = 1'b0; end
                endcase
                w = 8'(r % 256);
                m_z = (w == 8'h00);
            end
        endcase
        if (nw == 1) begin
            m_rf[d] = w;
            m_result = w;
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s,
                          input logic [7:0] im, output logic [7:0] ores, output logic oz,
                          output logic oc, output int olat, output int elat);
        int enw, nw;
        logic [7:0] ew;
        model_apply(op, d, s, im, elat, enw, ew);
        @(negedge clk);
        cmd_op = op; cmd_dst = d; cmd_src = s; cmd_imm = im; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        olat = 0;
        nw = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rf_we) begin
                nw++;
                chk("wr_addr", 32'(rf_addr), 32'(d));
                chk("wr_data", 32'(rf_wdata), 32'(ew));
            end
            if (done) begin
                olat = k;
                break;
            end
        end
        chk("wr_count", nw, enw);
        chk("ready_at_done", 32'(cmd_ready), 1);
        ores = result; oz = flag_zero; oc = flag_carry;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] dst;
        logic [3:0] src;
        logic [7:0] imm;
        logic [7:0] res;
        logic       z;
        logic       c;
        int         lat;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [7:0] r;
        logic z, c;
        int lat, elat, bad;
        logic [2:0] op;

        tbl[0]  = '{3'd1, 4'd3, 4'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, 2};
        tbl[1]  = '{3'd2, 4'd7, 4'd3, 8'h00, 8'h5A, 1'b0, 1'b0, 3};
        tbl[2]  = '{3'd1, 4'd1, 4'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 2};
        tbl[3]  = '{3'd1, 4'd2, 4'd0, 8'h20, 8'h20, 1'b0, 1'b0, 2};
        tbl[4]  = '{3'd3, 4'd1, 4'd2, 8'h00, 8'h10, 1'b0, 1'b1, 4};
        tbl[5]  = '{3'd4, 4'd1, 4'd1, 8'h00, 8'h00, 1'b1, 1'b0, 4};
        tbl[6]  = '{3'd1, 4'd4, 4'd0, 8'h01, 8'h01, 1'b1, 1'b0, 2};
        tbl[7]  = '{3'd4, 4'd1, 4'd4, 8'h00, 8'hFF, 1'b0, 1'b1, 4};
        tbl[8]  = '{3'd1, 4'd5, 4'd0, 8'h81, 8'h81, 1'b0, 1'b1, 2};
        tbl[9]  = '{3'd6, 4'd5, 4'd0, 8'h00, 8'h81, 1'b0, 1'b1, 2};
        tbl[10] = '{3'd3, 4'd5, 4'd5, 8'h00, 8'h02, 1'b0, 1'b1, 4};
        tbl[11] = '{3'd0, 4'd9, 4'd9, 8'hEE, 8'h02, 1'b0, 1'b1, 1};
        tbl[12] = '{3'd5, 4'd5, 4'd4, 8'h00, 8'h00, 1'b1, 1'b0, 4};
        tbl[13] = '{3'd7, 4'd3, 4'd1, 8'h00, 8'hA5, 1'b0, 1'b0, 4};

        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        m_result = 8'h00; m_z = 1'b0; m_c = 1'b0;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 4'd0; cmd_src = 4'd0; cmd_imm = 8'd0;
        rst_n = 1'b0; tb_clr = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", {30'd0, flag_zero, flag_carry}, 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_addr", 32'(rf_addr), 0);
        rst_n = 1'b1; tb_clr = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_cmd(tbl[i].op, tbl[i].dst, tbl[i].src, tbl[i].imm, r, z, c, lat, elat);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_res", i), 32'(r), 32'(tbl[i].res));
            chk($sformatf("v%0d_zero", i), 32'(z), 32'(tbl[i].z));
            chk($sformatf("v%0d_carry", i), 32'(c), 32'(tbl[i].c));
        end

        // Back-to-back LDIs with cmd_valid held high
        model_apply(3'd1, 4'd8, 4'd0, 8'h11, lat, bad, r);
        model_apply(3'd1, 4'd9, 4'd0, 8'h22, lat, bad, r);
        @(negedge clk);
        cmd_op = 3'd1; cmd_dst = 4'd8; cmd_imm = 8'h11; cmd_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_c1", 32'(cmd_ready), 0);
        chk("b2b_w1", {23'd0, rf_we, rf_addr, 4'd0} | 32'(rf_wdata), {23'd0, 1'b1, 4'd8, 4'd0} | 32'h11);
        cmd_dst = 4'd9; cmd_imm = 8'h22;
        @(negedge clk);
        chk("b2b_done_c2", {30'd0, done, cmd_ready}, 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_w2", {23'd0, rf_we, rf_addr, 4'd0} | 32'(rf_wdata), {23'd0, 1'b1, 4'd9, 4'd0} | 32'h22);
        @(negedge clk);
        chk("b2b_done_c4", 32'(done), 1);
        chk("b2b_result", 32'(result), 32'h22);

        // Reset during RD_SRC of an ADD
        @(negedge clk);
        cmd_op = 3'd3; cmd_dst = 4'd1; cmd_src = 4'd2; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_c1_addr", 32'(rf_addr), 1);
        @(negedge clk);
        chk("abort_c2_addr", 32'(rf_addr), 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (rf_we || done) bad++;
            @(negedge clk);
        end
        chk("abort_no_activity", bad, 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_flags", {30'd0, flag_zero, flag_carry}, 0);
        m_result = 8'h00; m_z = 1'b0; m_c = 1'b0;

        // Reset arriving in the WRITE cycle must suppress the strobe immediately
        cmd_op = 3'd1; cmd_dst = 4'd6; cmd_imm = 8'h77; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("gate_we_before", 32'(rf_we), 1);
        rst_n = 1'b0;
        #1 chk("gate_we_during", 32'(rf_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (rf_we || done) bad++;
            @(negedge clk);
        end
        chk("gate_no_activity", bad, 0);
        chk("gate_r6_kept", 32'(rf[6]), 32'(m_rf[6]));

        // Random commands against the model
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            do_cmd(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), r, z, c, lat, elat);
            chk($sformatf("rnd%0d_lat", i), lat, elat);
            chk($sformatf("rnd%0d_res", i), 32'(r), 32'(m_result));
            chk($sformatf("rnd%0d_flags", i), {30'd0, z, c}, {30'd0, m_z, m_c});
        end
        for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(m_rf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command sequencer that sits directly upstream of the CPU's single-port register file and drives its shared address, write-enable and write-data lines. It accepts one register-transfer or ALU command at a time over a valid/ready handshake. Because the register file has one address port, each command runs as a multi-cycle sequence of reads and a final write. The block returns the written or read value together with zero/carry flags to the control unit.

## Interface
- DATA_WIDTH, 8, bits per register and operand
- ADDR_WIDTH, 4, register address bits (2**ADDR_WIDTH registers)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  000 NOP, 001 LDI, 010 MOV, 011 ADD, 100 SUB, 101 AND, 110 RD, 111 XOR
- cmd_dst  in  ADDR_WIDTH  destination (and first operand) register
- cmd_src  in  ADDR_WIDTH  source register
- cmd_imm  in  DATA_WIDTH  immediate for LDI
- rf_address  out  ADDR_WIDTH  register file address
- rf_write_enable  out  1  register file write strobe
- rf_write_data  out  DATA_WIDTH  register file write data
- rf_read_data  in  DATA_WIDTH  register file asynchronous read data for rf_address
- done  out  1  one-cycle completion pulse
- result  out  DATA_WIDTH  last written value (or value read by RD)
- flag_zero  out  1  last ALU result was zero
- flag_carry  out  1  ADD carry-out / SUB borrow

## Operation
- **States:** IDLE, RD_DST, RD_SRC, WRITE.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, latch op, dst, src and imm.
  - Next state by op: NOP stays in IDLE; LDI goes to WRITE; MOV goes to RD_SRC; ADD/SUB/AND/XOR/RD go to RD_DST.
- **RD_DST**
  - rf_address=dst.
  - Latch rf_read_data into operand A at the clock edge.
  - RD returns to IDLE; all other ops go to RD_SRC.
- **RD_SRC**
  - rf_address=src.
  - Latch rf_read_data into operand B.
  - Next state WRITE.
- **WRITE**
  - rf_address=dst, rf_write_enable=1, rf_write_data=computed value.
  - Computed value by op: LDI imm; MOV B; ADD A+B; SUB A−B; AND A&B; XOR A^B.
  - Next state IDLE.
- **Completion:**
  - done is registered and pulses high for exactly one cycle, the cycle after the final state.
  - For NOP, that is the cycle after acceptance.
  - result updates in that same cycle to the written value (RD: operand A) and holds until the next completing command. NOP leaves result unchanged.
- **Arithmetic:**
  - Computed at DATA_WIDTH+1 bits; the low DATA_WIDTH bits are written.
  - ADD: flag_carry = bit DATA_WIDTH.
  - SUB: flag_carry = 1 iff A<B (borrow).
  - AND/XOR: flag_carry=0.
  - flag_zero = (written value==0) for ADD/SUB/AND/XOR.
  - LDI, MOV, RD and NOP leave both flags unchanged.
- **dst==src** is legal. Both reads return the same register and ADD doubles it.
- **Outside WRITE:** rf_write_enable=0 and rf_write_data=0. rf_address=0 in IDLE.
- **cmd_ready=0** in every state except IDLE. Inputs other than cmd_valid are ignored while busy.

## Timing
- **Reset:**
  - While reset=0 at a rising edge: state goes to IDLE; done, result, flag_zero and flag_carry go to 0; latched operands are cleared.
  - rf_write_enable is additionally gated combinationally by reset, so it is 0 in any cycle where reset=0.
  - Reset mid-command therefore aborts with no write and no done.
- **Latency, acceptance edge = cycle 0:**
  - NOP: done in cycle 1.
  - LDI: WRITE in cycle 1, done in cycle 2.
  - RD: RD_DST in cycle 1, done in cycle 2.
  - MOV: RD_SRC in cycle 1, WRITE in cycle 2, done in cycle 3.
  - ALU ops: RD_DST, RD_SRC and WRITE in cycles 1–3, done in cycle 4.
- **Back-to-back:**
  - cmd_ready is high in the done cycle, so a new command can be accepted there.
  - Peak throughput is one LDI every 2 cycles.
- **Handshake:** a command is accepted only on an edge with cmd_valid=1 and cmd_ready=1. cmd_valid held high through a busy period is accepted at the next IDLE edge.

## Test plan
- **Reset then LDI:** reset low 2 cycles, then LDI dst=3 imm=0x5A.
  - Cycle 1: rf_address=3, rf_write_enable=1, rf_write_data=0x5A.
  - Cycle 2: done=1, result=0x5A, flags=0/0.
- **MOV:** with R3=0x5A, MOV dst=7 src=3.
  - Cycle 1: rf_address=3.
  - Cycle 2: write R7=0x5A.
  - Cycle 3: done, result=0x5A.
- **ALU flags:**
  - R1=0xF0, R2=0x20, ADD dst=1 src=2: write 0x10, carry=1, zero=0, done in cycle 4.
  - Then SUB dst=1 src=1: 0x00, zero=1, carry=0.
  - SUB 0x00−0x01: 0xFF, carry=1, zero=0.
- **Back-to-back:** cmd_valid held high with two LDIs.
  - cmd_ready=0 in cycle 1.
  - Second command accepted at the done-cycle edge.
  - Second write appears 2 cycles after the first.
- **Reset mid-op:** reset=0 during the RD_SRC cycle of an ADD.
  - rf_write_enable stays 0 throughout; no done pulse.
  - result and flags read 0 after reset.
- **RD and same-register ADD:**
  - R5=0x81, RD dst=5: done in cycle 2, result=0x81, no write, flags unchanged.
  - ADD dst=5 src=5: R5=0x02, carry=1.
